// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, data, optional parity and stop bits,
// driving the serializer controls and the select of the registered TX output mux.
module uart_tx_fsm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1,
    localparam int unsigned CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    output logic             Ser_Load,
    output logic             Ser_En,
    output logic [CNT_W-1:0] Bit_Cnt,
    output logic [1:0]       Mux_Sel,
    output logic             Busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_STOP   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    state_t state;
    logic   stop_cnt;
    logic   par_en_q;
    logic   last_stop;
    logic   accept;

    assign last_stop = (stop_cnt == LAST_STOP);
    // Gated by RST so the load strobe stays low while reset is held.
    assign accept    = RST && Data_Valid &&
                       ((state == IDLE) || ((state == STOP) && last_stop));

    always_comb begin
        Mux_Sel  = SEL_STOP;
        Ser_En   = 1'b0;
        Ser_Load = accept;
        case (state)
            START:   Mux_Sel = SEL_START;
            DATA: begin
                Mux_Sel = SEL_DATA;
                Ser_En  = 1'b1;
            end
            PARITY:  Mux_Sel = SEL_PARITY;
            default: Mux_Sel = SEL_STOP;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            Bit_Cnt  <= '0;
            stop_cnt <= 1'b0;
            par_en_q <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            Busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        par_en_q <= PAR_EN;
                        state    <= START;
                    end
                end
                START: begin
                    Bit_Cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (Bit_Cnt == LAST_BIT) begin
                        Bit_Cnt <= '0;
                        state   <= par_en_q ? PARITY : STOP;
                    end else begin
                        Bit_Cnt <= Bit_Cnt + CNT_W'(1);
                    end
                end
                PARITY: state <= STOP;
                STOP: begin
                    if (last_stop) begin
                        stop_cnt <= 1'b0;
                        if (Data_Valid) begin
                            par_en_q <= PAR_EN;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    Bit_Cnt  <= '0;
                    stop_cnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
Frame sequencer for the UART transmitter. It accepts a byte request and drives the serializer enable/load and the 2-bit select of the registered TX output mux. The mux select encoding is 00 = start (0), 01 = stop/idle (1), 10 = serial data, 11 = parity. The block sits between the host-side Data_Valid/PAR_EN inputs and the serializer/parity/output-mux datapath. One CLK cycle equals one bit period.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..16).
STOP_BITS, 1, number of stop bits per frame (1 or 2).

Ports:
CLK  input  1  bit-rate clock, rising edge.
RST  input  1  asynchronous active-low reset.
Data_Valid  input  1  host request; sampled only when the FSM can accept a frame.
PAR_EN  input  1  parity enable; captured on frame accept.
Ser_Load  output  1  one-cycle pulse; serializer/parity latch the parallel data.
Ser_En  output  1  serializer shift enable; high during DATA cycles.
Bit_Cnt  output  $clog2(DATA_WIDTH)  index of the current data bit, 0 = LSB.
Mux_Sel  output  2  select to the output mux.
Busy  output  1  frame in progress, aligned to the mux's registered TX output.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. State, counters and the parity-enable latch are registered; Mux_Sel, Ser_En and Ser_Load are decoded combinationally from state and inputs.
- Reset (any time, including mid-frame), all asynchronous:
  - state = IDLE; Bit_Cnt = 0; stop counter = 0; par_en_q = 0; Busy = 0.
  - Combinational outputs take their IDLE values: Mux_Sel = 01, Ser_En = 0, Ser_Load = 0.
  - A frame interrupted by reset is abandoned, never resumed.
- Frame accept: Ser_Load = Data_Valid when state==IDLE, or when state==STOP on its last stop cycle. On accept, par_en_q <= PAR_EN and next state = START.
- IDLE:
  - Mux_Sel = 01.
  - Data_Valid=1 -> START; otherwise stay in IDLE.
- START: exactly 1 cycle, Mux_Sel = 00, then -> DATA with Bit_Cnt = 0.
- DATA: exactly DATA_WIDTH cycles.
  - Mux_Sel = 10, Ser_En = 1.
  - Bit_Cnt increments each cycle.
  - When Bit_Cnt == DATA_WIDTH-1: Bit_Cnt <= 0, then -> PARITY if par_en_q, else -> STOP.
- PARITY: exactly 1 cycle, Mux_Sel = 11, then -> STOP.
- STOP: STOP_BITS cycles, Mux_Sel = 01; the stop counter clears on exit. On the last stop cycle:
  - Data_Valid=1 -> START (back-to-back frame, no idle gap, Ser_Load pulses).
  - Data_Valid=0 -> IDLE.
- Data_Valid in START/DATA/PARITY, or in a non-final STOP cycle, is ignored: no queuing, no Ser_Load.
- PAR_EN changes mid-frame have no effect; only the captured value is used.
- Ser_En=0 and Ser_Load=0 in every state other than those listed above.
- Busy <= (state != IDLE), registered. This gives the same one-cycle lag as the mux output register, so Busy covers exactly the TX_Out start..stop bits.
- Frame length in cycles = 1 + DATA_WIDTH + par_en_q + STOP_BITS.
- No illegal-state lockup: any unreachable encoding -> IDLE on the next edge.

Test Plan:
1. Reset, then hold Data_Valid=0 for 20 cycles -> Mux_Sel=01, Ser_En=0, Ser_Load=0, Busy=0 throughout.
2. DATA_WIDTH=8, STOP_BITS=1, PAR_EN=1, one-cycle Data_Valid pulse at cycle 0 -> expected sequence:
   - Ser_Load=1 at cycle 0.
   - Mux_Sel: 00 at cycle 1; 10 at cycles 2-9 with Ser_En=1 and Bit_Cnt 0..7; 11 at cycle 10; 01 at cycle 11.
   - IDLE at cycle 12.
   - Busy=1 at cycles 2-12.
3. Same frame with PAR_EN=0 -> PARITY skipped; Mux_Sel=01 at cycle 10; IDLE at cycle 11; a frame of 10 bits.
4. STOP_BITS=2, Data_Valid held at 1 continuously -> frames are back-to-back:
   - Ser_Load pulses every 12 cycles (PAR_EN=1).
   - Two 01 cycles, then 00 immediately; Busy never drops.
5. Data_Valid pulsed during DATA (cycle 5) and PAR_EN toggled during DATA -> no Ser_Load, frame unchanged, returns to IDLE.
6. RST asserted low at cycle 6 of a frame -> Mux_Sel=01, Ser_En=0, Bit_Cnt=0, Busy=0 immediately. After release, a new Data_Valid starts a clean full frame.
